// File: rtl/cga_vram_fetch.sv
// rtl/cga_vram_fetch.sv - CGA/Tandy display VRAM fetch sequencer with CPU slot interleave
module cga_vram_fetch #(
  parameter int VRAM_AW = 15,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hres_mode,
  input  logic               grph_mode,
  input  logic               tandy_16_mode,
  input  logic               display_enable,
  input  logic [13:0]        crtc_ma,
  input  logic [4:0]         crtc_ra,
  output logic [4:0]         clk_seq,
  output logic               crtc_clk,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  output logic               vram_read_char,
  output logic               vram_read_att,
  output logic               charrom_read,
  output logic               disp_pipeline,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack
);

  localparam logic [3:0] CHAR_SLOT    = 4'(RD_LAT);
  localparam logic [3:0] ATT_SLOT     = 4'(RD_LAT + 2);
  localparam logic [3:0] CPU_CAP_SLOT = 4'(RD_LAT + 6);

  typedef enum logic {C_IDLE, C_BUSY} cpu_state_t;

  cpu_state_t         state, state_n;
  logic               hres_q, hres_n;
  logic [13:0]        ma_q, ma_n;
  logic [4:0]         ra_q, ra_n;
  logic               grph_q, grph_n, tandy_q, tandy_n;
  logic               blank_q, blank_n;
  logic               cpu_rd_q, cpu_rd_n, cpu_blank_q, cpu_blank_n;
  logic               rd_cap_q, rd_cap_n;
  logic [7:0]         rdata_q, rdata_n;
  logic [4:0]         seq_n;
  logic [3:0]         sn;
  logic               fetch_n, blank_start, slot_start;
  logic               crtc_clk_n, we_n, rc_n, ra_strb_n, cr_n, dp_n, ack_n;
  logic [VRAM_AW-1:0] addr_n;
  logic [7:0]         wdata_n;

  function automatic logic [14:0] fetch_addr(input logic [13:0] ma, input logic [4:0] ra,
                                             input logic grph, input logic tandy, input logic b);
    logic [14:0] a;
    if (grph && tandy)
      a = {ra[1:0], ma[11:0], b};
    else if (grph)
      a = {1'b0, ra[0], ma[11:0], b};
    else
      a = {ma, b};
    return a;
  endfunction

  // Every output is registered; this block computes the values for the slot about to start.
  always_comb begin
    seq_n       = clk_seq + 5'd1;
    sn          = seq_n[3:0];
    fetch_n     = ~seq_n[4] | hres_q;
    state_n     = state;
    hres_n      = (clk_seq == 5'd0) ? hres_mode : hres_q;
    ma_n        = ma_q;
    ra_n        = ra_q;
    grph_n      = grph_q;
    tandy_n     = tandy_q;
    blank_n     = blank_q;
    cpu_rd_n    = cpu_rd_q;
    cpu_blank_n = cpu_blank_q;
    rd_cap_n    = 1'b0;
    rdata_n     = rd_cap_q ? vram_rdata : rdata_q;
    addr_n      = vram_addr;
    wdata_n     = vram_wdata;
    we_n        = 1'b0;
    ack_n       = 1'b0;

    blank_start = fetch_n && (sn == 4'd0) && !display_enable && cpu_req && (state == C_IDLE);
    slot_start  = (sn == 4'd6) && cpu_req && (state == C_IDLE);

    if (fetch_n && (sn == 4'd0)) begin
      ma_n    = crtc_ma;
      ra_n    = crtc_ra;
      grph_n  = grph_mode;
      tandy_n = tandy_16_mode;
      blank_n = blank_start;
      addr_n  = blank_start ? cpu_addr
                            : VRAM_AW'(fetch_addr(crtc_ma, crtc_ra, grph_mode, tandy_16_mode, 1'b0));
    end else if (fetch_n && (sn == 4'd2)) begin
      addr_n = VRAM_AW'(fetch_addr(ma_q, ra_q, grph_q, tandy_q, 1'b1));
    end else if (slot_start) begin
      addr_n = cpu_addr;
    end

    if (blank_start || slot_start) begin
      state_n     = C_BUSY;
      cpu_rd_n    = ~cpu_we;
      cpu_blank_n = blank_start;
      we_n        = cpu_we;
      if (cpu_we)
        wdata_n = cpu_wdata;
    end

    if (state == C_BUSY) begin
      rd_cap_n = cpu_rd_q && (sn == (cpu_blank_q ? CHAR_SLOT : CPU_CAP_SLOT));
      if (sn == (cpu_blank_q ? 4'd2 : 4'd8)) begin
        ack_n   = 1'b1;
        state_n = C_IDLE;
      end
    end

    crtc_clk_n = (sn == 4'd15) && (seq_n[4] || hres_q);
    rc_n       = fetch_n && (sn == CHAR_SLOT) && !blank_n;
    ra_strb_n  = fetch_n && (sn == ATT_SLOT);
    cr_n       = fetch_n && (sn == 4'd5);
    dp_n       = fetch_n && (sn == 4'd15);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= C_IDLE;
      clk_seq        <= 5'd0;
      hres_q         <= 1'b0;
      ma_q           <= 14'd0;
      ra_q           <= 5'd0;
      grph_q         <= 1'b0;
      tandy_q        <= 1'b0;
      blank_q        <= 1'b0;
      cpu_rd_q       <= 1'b0;
      cpu_blank_q    <= 1'b0;
      rd_cap_q       <= 1'b0;
      rdata_q        <= 8'd0;
      crtc_clk       <= 1'b0;
      vram_addr      <= '0;
      vram_we        <= 1'b0;
      vram_wdata     <= 8'd0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
      cpu_ack        <= 1'b0;
    end else begin
      state          <= state_n;
      clk_seq        <= seq_n;
      hres_q         <= hres_n;
      ma_q           <= ma_n;
      ra_q           <= ra_n;
      grph_q         <= grph_n;
      tandy_q        <= tandy_n;
      blank_q        <= blank_n;
      cpu_rd_q       <= cpu_rd_n;
      cpu_blank_q    <= cpu_blank_n;
      rd_cap_q       <= rd_cap_n;
      rdata_q        <= rdata_n;
      crtc_clk       <= crtc_clk_n;
      vram_addr      <= addr_n;
      vram_we        <= we_n;
      vram_wdata     <= wdata_n;
      vram_read_char <= rc_n;
      vram_read_att  <= ra_strb_n;
      charrom_read   <= cr_n;
      disp_pipeline  <= dp_n;
      cpu_ack        <= ack_n;
    end
  end

  // Read data passes straight through in its capture cycle so it is valid alongside cpu_ack.
  assign cpu_rdata = rd_cap_q ? vram_rdata : rdata_q;

endmodule

// File: doc/cga_vram_fetch.md
Name: cga_vram_fetch

Overview:
- Display-side VRAM fetch sequencer for the CGA/Tandy video path.
- Runs the per-character clock sequence and generates VRAM addresses from the CRTC memory/row address.
- Drives the pixel stage's latch strobes: vram_read_char, vram_read_att, charrom_read, disp_pipeline.
- Interleaves CPU read/write accesses into fixed VRAM slots using a req/ack handshake.

Parameters:
- VRAM_AW, 15, VRAM byte address width (32 KB Tandy; CGA uses the low 14 bits).
- RD_LAT, 2, VRAM read latency in clk cycles from vram_addr to valid vram_rdata; legal values are 1 or 2.

Ports:
- clk  in  1  pixel clock (28.636 MHz)
- reset  in  1  asynchronous, active-high reset
- hres_mode  in  1  80-column text / Tandy hi-res fetch rate
- grph_mode  in  1  graphics addressing
- tandy_16_mode  in  1  4-bank Tandy graphics addressing
- display_enable  in  1  CRTC active display
- crtc_ma  in  14  CRTC memory address
- crtc_ra  in  5  CRTC row address
- clk_seq  out  5  free-running sequence counter
- crtc_clk  out  1  one-cycle character-clock enable to the CRTC
- vram_addr  out  VRAM_AW  VRAM address
- vram_we  out  1  VRAM write strobe
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data
- vram_read_char  out  1  char/graphics byte 0 valid strobe
- vram_read_att  out  1  attribute/graphics byte 1 valid strobe
- charrom_read  out  1  character ROM lookup strobe
- disp_pipeline  out  1  pixel pipeline advance strobe
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write
- cpu_addr  in  VRAM_AW  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- cpu_ack  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): clk_seq=0, all strobes/vram_we/cpu_ack=0, vram_addr=0, cpu_rdata=0, no pending access. A transaction in flight at reset is dropped with no ack; the requester re-issues.
- clk_seq increments every clk and wraps 31->0. Slot index s = clk_seq[3:0]; a half-window is 16 clk.
- hres_mode is sampled only at clk_seq=0 and held for the 32-clk window.
- hres_mode=1: both half-windows are display fetch windows; crtc_clk pulses at s=15.
- hres_mode=0: only the first half (clk_seq[4]=0) fetches; crtc_clk pulses only at clk_seq=31.
- Display fetch in each fetch half:
  - s=0: vram_addr = byte-0 address.
  - s=2: vram_addr = byte-1 address.
  - s=RD_LAT: vram_read_char pulses.
  - s=2+RD_LAT: vram_read_att pulses.
  - s=5: charrom_read pulses.
  - s=15: disp_pipeline pulses.
- Address generation (crtc_ma and crtc_ra sampled at s=0):
  - text: byte0 = {crtc_ma,0}, byte1 = {crtc_ma,1}.
  - CGA graphics: {0, crtc_ra[0], crtc_ma[11:0], b}.
  - Tandy 16 graphics: {crtc_ra[1:0], crtc_ma[11:0], b}.
  - b = 0 for byte 0, b = 1 for byte 1.
- CPU slot at s=6 of every half-window, in both modes:
  - If cpu_req is high at the s=6 edge, vram_addr = cpu_addr.
  - Write: vram_we=1 and vram_wdata=cpu_wdata for exactly one cycle at s=6.
  - Read: cpu_rdata is captured at s=6+RD_LAT.
  - cpu_ack pulses at s=8 for both reads and writes. cpu_rdata is valid from the cpu_ack cycle until the next read completes.
- Extra blank slot: if display_enable=0 at s=0 of a fetch half and cpu_req=1, the CPU takes s=0 instead of the byte-0 fetch.
  - vram_read_char is suppressed in that half.
  - The CPU access completes with cpu_ack at s=2.
  - One request is served per slot. After cpu_ack the requester drops cpu_req; a request still high at the next slot is treated as a new access.
- cpu_req rising after s=6 waits for the next eligible slot. Worst-case latency is 18 clk.
- No simultaneous drive: in any cycle vram_addr has exactly one owner (display or CPU). vram_we is never asserted in a display slot.
- At most one of vram_read_char, vram_read_att, charrom_read, disp_pipeline is high in any cycle.

Test Plan:
- Reset release, hres_mode=1: clk_seq counts 0..31 then wraps. crtc_clk pulses at clk_seq=15 and 31. vram_read_char at s=2, vram_read_att at s=4, charrom_read at s=5, disp_pipeline at s=15.
- hres_mode=0, text, crtc_ma=0x0123: vram_addr=0x0246 at s=0 and 0x0247 at s=2. No fetch strobes in the second half. crtc_clk pulses only at clk_seq=31.
- Graphics addressing with crtc_ma=0x0ABC, crtc_ra=3: CGA mode gives byte0 addr 0x3578. Tandy_16 mode gives byte0 addr 0x7578.
- CPU write: cpu_req=1 at s=3 with addr 0x1FFF, data 0x5A, display_enable=1. vram_we is high only at s=6 with vram_addr=0x1FFF and vram_wdata=0x5A; cpu_ack at s=8.
- CPU read during blanking: display_enable=0, cpu_req=1 before s=0, VRAM model returns 0xC3. CPU gets s=0 and vram_read_char is suppressed. cpu_ack at s=2 with cpu_rdata=0xC3.
- Assert reset at s=7 during a pending CPU read: all outputs return to 0 immediately and no cpu_ack is issued. After release, a re-issued request completes normally.
